// File: rtl/alu_issue_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// alu_issue_ctrl_pkg
// Shared definitions for the 4-DSP complex ALU issue sequencer:
//   - instruction opcode encodings
//   - per-core DSP control field widths and control constants
//   - sequencer FSM state type and an opcode legality helper
// ---------------------------------------------------------------------------
package alu_issue_ctrl_pkg;

    localparam int NUM_CORES = 4;
    localparam int ALUMODE_W = 4;
    localparam int INMODE_W  = 5;
    localparam int OPMODE_W  = 7;

    localparam logic [2:0] OP_NOP    = 3'b000;
    localparam logic [2:0] OP_CMULT  = 3'b100;
    localparam logic [2:0] OP_MULADD = 3'b101;
    localparam logic [2:0] OP_MULSUB = 3'b110;

    // X=M, Y=M, Z=0 : plain multiply
    localparam logic [OPMODE_W-1:0]  OPMODE_M     = 7'h05;
    // X=M, Y=M, Z=C : multiply combined with C
    localparam logic [OPMODE_W-1:0]  OPMODE_CM    = 7'h35;
    localparam logic [ALUMODE_W-1:0] ALUMODE_ADD  = 4'h0;
    // Z - (X+Y), i.e. C - M
    localparam logic [ALUMODE_W-1:0] ALUMODE_ZSUB = 4'h3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    function automatic logic op_is_legal(input logic [2:0] op);
        return (op == OP_NOP) || (op == OP_CMULT) ||
               (op == OP_MULADD) || (op == OP_MULSUB);
    endfunction

endpackage

// File: rtl/alu_ctrl_rom.sv
// ---------------------------------------------------------------------------
// alu_ctrl_rom
// Combinational opcode -> DSP control lookup for all four cores.
// Core 1 occupies the MSB field of every packed output.
// Ports:
//   i_opcode   [2:0]   latched instruction opcode
//   o_alumode  [15:0]  4 bits per core
//   o_inmode   [19:0]  5 bits per core (always 0: A2/B2 selected)
//   o_opmode   [27:0]  7 bits per core
// ---------------------------------------------------------------------------
module alu_ctrl_rom
    import alu_issue_ctrl_pkg::*;
(
    input  logic [2:0]                     i_opcode,
    output logic [NUM_CORES*ALUMODE_W-1:0] o_alumode,
    output logic [NUM_CORES*INMODE_W-1:0]  o_inmode,
    output logic [NUM_CORES*OPMODE_W-1:0]  o_opmode
);

    always_comb begin
        o_alumode = '0;
        o_inmode  = '0;
        o_opmode  = '0;
        case (i_opcode)
            OP_CMULT: begin
                o_opmode  = {OPMODE_M, OPMODE_M, OPMODE_M, OPMODE_M};
                o_alumode = {ALUMODE_ADD, ALUMODE_ADD, ALUMODE_ADD, ALUMODE_ADD};
            end
            OP_MULADD: begin
                // Cores 1/3 accumulate C, cores 2/4 are plain multiplies
                o_opmode  = {OPMODE_CM, OPMODE_M, OPMODE_CM, OPMODE_M};
                o_alumode = {ALUMODE_ADD, ALUMODE_ADD, ALUMODE_ADD, ALUMODE_ADD};
            end
            OP_MULSUB: begin
                o_opmode  = {OPMODE_CM, OPMODE_M, OPMODE_CM, OPMODE_M};
                o_alumode = {ALUMODE_ZSUB, ALUMODE_ADD, ALUMODE_ZSUB, ALUMODE_ADD};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// ---------------------------------------------------------------------------
// alu_issue_ctrl
// Instruction issue sequencer for the 4-DSP complex ALU. Accepts repeat-count
// instructions, issues one ALU op per granted cycle, and tracks the ALU
// pipeline so res_valid/res_last line up with the ALU dout.
// Optional feature: define ALU_ISSUE_CNT_EN to add issue_cnt[31:0], a
// wrapping count of issue cycles (stalls not counted).
// Ports:
//   clk, rst (async, active-low)
//   inst_valid/inst_ready, inst_opcode[2:0], inst_count[CNT_WIDTH-1:0]
//   opnd_req/opnd_gnt            operand fetch handshake
//   opcode, alumode, inmode, opmode, cea2, ceb2, usemult   ALU control
//   res_valid, res_last          ALU dout qualifiers
//   busy, illegal                status
// ---------------------------------------------------------------------------
module alu_issue_ctrl
    import alu_issue_ctrl_pkg::*;
#(
    parameter int ALU_LATENCY = 4,
    parameter int CNT_WIDTH   = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 inst_valid,
    output logic                 inst_ready,
    input  logic [2:0]           inst_opcode,
    input  logic [CNT_WIDTH-1:0] inst_count,
    output logic                 opnd_req,
    input  logic                 opnd_gnt,
    output logic [2:0]           opcode,
    output logic [15:0]          alumode,
    output logic [19:0]          inmode,
    output logic [27:0]          opmode,
    output logic [3:0]           cea2,
    output logic [3:0]           ceb2,
    output logic [3:0]           usemult,
    output logic                 res_valid,
    output logic                 res_last,
    output logic                 busy,
    output logic                 illegal
`ifdef ALU_ISSUE_CNT_EN
    ,
    output logic [31:0]          issue_cnt
`endif
);

    state_e                 r_state;
    state_e                 w_state_next;
    logic [2:0]             r_opcode;
    logic [CNT_WIDTH-1:0]   r_count;
    logic [ALU_LATENCY-1:0] r_pipe_vld;
    logic [ALU_LATENCY-1:0] r_pipe_last;
    logic [ALU_LATENCY-1:0] w_pipe_vld_nxt;
    logic [ALU_LATENCY-1:0] w_pipe_last_nxt;
    logic                   r_illegal;
    logic                   w_accept;
    logic                   w_start;
    logic                   w_issue;
    logic                   w_issue_last;
    logic                   w_pipe_busy;
    logic                   w_pipe_drains;
    logic [15:0]            w_rom_alumode;
    logic [19:0]            w_rom_inmode;
    logic [27:0]            w_rom_opmode;

    alu_ctrl_rom u_rom (
        .i_opcode  (r_opcode),
        .o_alumode (w_rom_alumode),
        .o_inmode  (w_rom_inmode),
        .o_opmode  (w_rom_opmode)
    );

    assign inst_ready   = (r_state == ST_IDLE) & rst;
    assign w_accept     = inst_valid & inst_ready;
    assign w_start      = w_accept & op_is_legal(inst_opcode) & (inst_opcode != OP_NOP);
    assign w_issue      = (r_state == ST_ISSUE) & opnd_gnt;
    assign w_issue_last = w_issue & (r_count == '0);
    assign w_pipe_busy  = |r_pipe_vld;

    // Pipe shift and "empty after this cycle" detection; the single-stage
    // case has no lower stages to inspect.
    generate
        if (ALU_LATENCY == 1) begin : g_pipe_one
            assign w_pipe_vld_nxt  = w_issue;
            assign w_pipe_last_nxt = w_issue_last;
            assign w_pipe_drains   = 1'b1;
        end else begin : g_pipe_multi
            assign w_pipe_vld_nxt  = {r_pipe_vld[ALU_LATENCY-2:0], w_issue};
            assign w_pipe_last_nxt = {r_pipe_last[ALU_LATENCY-2:0], w_issue_last};
            assign w_pipe_drains   = ~|r_pipe_vld[ALU_LATENCY-2:0];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_opcode    <= '0;
            r_count     <= '0;
            r_pipe_vld  <= '0;
            r_pipe_last <= '0;
            r_illegal   <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_pipe_vld  <= w_pipe_vld_nxt;
            r_pipe_last <= w_pipe_last_nxt;
            r_illegal   <= w_accept & ~op_is_legal(inst_opcode);
            if (w_start) begin
                r_opcode <= inst_opcode;
                r_count  <= inst_count;
            end else if (w_issue && !w_issue_last) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (w_start)       w_state_next = ST_ISSUE;
            ST_ISSUE: if (w_issue_last)  w_state_next = ST_DRAIN;
            // Leave DRAIN once only the final stage is occupied, so busy
            // falls in the cycle right after the last result.
            ST_DRAIN: if (w_pipe_drains) w_state_next = ST_IDLE;
            default:                     w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        opnd_req = (r_state == ST_ISSUE);
        alumode  = '0;
        inmode   = '0;
        opmode   = '0;
        cea2     = '0;
        ceb2     = '0;
        usemult  = '0;
        if (r_state == ST_ISSUE) begin
            alumode = w_rom_alumode;
            inmode  = w_rom_inmode;
            usemult = 4'b1111;
            // A stall keeps A2/B2 held and feeds no new op into the DSPs
            if (w_issue) begin
                opmode = w_rom_opmode;
                cea2   = 4'b1111;
                ceb2   = 4'b1111;
            end
        end
    end

    assign busy      = (r_state != ST_IDLE) | w_pipe_busy;
    // Opcode persists until the last result leaves the ALU
    assign opcode    = busy ? r_opcode : 3'b000;
    assign res_valid = r_pipe_vld[ALU_LATENCY-1];
    assign res_last  = r_pipe_last[ALU_LATENCY-1];
    assign illegal   = r_illegal;

`ifdef ALU_ISSUE_CNT_EN
    logic [31:0] r_issue_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_issue_cnt <= '0;
        end else if (w_issue) begin
            r_issue_cnt <= r_issue_cnt + 32'd1;
        end
    end

    assign issue_cnt = r_issue_cnt;
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
module tb_alu_issue_ctrl;

    localparam int LAT = 4;
    localparam logic [2:0] T_NOP    = 3'b000;
    localparam logic [2:0] T_CMULT  = 3'b100;
    localparam logic [2:0] T_MULADD = 3'b101;
    localparam logic [2:0] T_MULSUB = 3'b110;

    logic        clk;
    logic        rst;
    logic        inst_valid;
    logic        inst_ready;
    logic [2:0]  inst_opcode;
    logic [7:0]  inst_count;
    logic        opnd_req;
    logic        opnd_gnt;
    logic [2:0]  opcode;
    logic [15:0] alumode;
    logic [19:0] inmode;
    logic [27:0] opmode;
    logic [3:0]  cea2;
    logic [3:0]  ceb2;
    logic [3:0]  usemult;
    logic        res_valid;
    logic        res_last;
    logic        busy;
    logic        illegal;
`ifdef ALU_ISSUE_CNT_EN
    logic [31:0] issue_cnt;
`endif

    alu_issue_ctrl #(.ALU_LATENCY(LAT), .CNT_WIDTH(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .inst_valid  (inst_valid),
        .inst_ready  (inst_ready),
        .inst_opcode (inst_opcode),
        .inst_count  (inst_count),
        .opnd_req    (opnd_req),
        .opnd_gnt    (opnd_gnt),
        .opcode      (opcode),
        .alumode     (alumode),
        .inmode      (inmode),
        .opmode      (opmode),
        .cea2        (cea2),
        .ceb2        (ceb2),
        .usemult     (usemult),
        .res_valid   (res_valid),
        .res_last    (res_last),
        .busy        (busy),
        .illegal     (illegal)
`ifdef ALU_ISSUE_CNT_EN
        ,
        .issue_cnt   (issue_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        int cyc;
        bit last;
    } exp_t;

    exp_t  sb[$];
    exp_t  mon_e;
    bit    gnt_q[$];
    int    gnt_pct = 100;
    longint model_issues = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    // Reference control packing: core k (1..4) sits at field 4-k.
    function automatic logic [27:0] ref_opmode(input logic [2:0] op);
        logic [27:0] v;
        logic [6:0]  m;
        v = '0;
        for (int core = 1; core <= 4; core++) begin
            if (op == T_CMULT || (core % 2) == 0) m = 7'h05;
            else m = 7'h35;
            v[(4-core)*7 +: 7] = m;
        end
        return v;
    endfunction

    function automatic logic [15:0] ref_alumode(input logic [2:0] op);
        logic [15:0] v;
        v = '0;
        for (int core = 1; core <= 4; core++)
            if (op == T_MULSUB && (core % 2) == 1) v[(4-core)*4 +: 4] = 4'h3;
        return v;
    endfunction

    // Result monitor: every res_valid must match the oldest pending issue.
    always @(negedge clk) begin
        if (rst && res_valid) begin
            if (sb.size() == 0) begin
                chk("res_unexpected", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                chk("res_cycle", cyc, mon_e.cyc);
                chk("res_last", res_last, mon_e.last);
            end
        end else if (rst && res_last) begin
            chk("res_last_stray", 1, 0);
        end
    end

    function automatic bit pick_gnt();
        if (gnt_q.size() > 0) return gnt_q.pop_front();
        return ($urandom_range(0, 99) < gnt_pct);
    endfunction

    task automatic run_inst(input logic [2:0] op, input int cnt);
        int  rem;
        int  guard;
        int  last_issue;
        bit  g;
        bit  legal;
        legal = (op == T_NOP) || (op == T_CMULT) || (op == T_MULADD) || (op == T_MULSUB);
        @(negedge clk);
        inst_valid  = 1'b1;
        inst_opcode = op;
        inst_count  = cnt[7:0];
        #1;
        chk("inst_ready_idle", inst_ready, 1);
        @(negedge clk);
        inst_valid = 1'b0;
        if (!legal || op == T_NOP) begin
            #1;
            chk("illegal_pulse", illegal, !legal);
            chk("no_opnd_req", opnd_req, 0);
            chk("ready_stays", inst_ready, 1);
            @(negedge clk);
            #1;
            chk("illegal_one_cycle", illegal, 0);
            chk("idle_not_busy", busy, 0);
            return;
        end
        rem = cnt + 1;
        guard = 0;
        last_issue = 0;
        while (rem > 0 && guard < 4000) begin
            g = pick_gnt();
            opnd_gnt = g;
            #1;
            chk("opnd_req", opnd_req, 1);
            chk("ready_low_issue", inst_ready, 0);
            if (g) begin
                chk("opmode", opmode, ref_opmode(op));
                chk("alumode", alumode, ref_alumode(op));
                chk("cea2_issue", cea2, 4'hF);
                chk("usemult", usemult, 4'hF);
                chk("opcode", opcode, op);
                sb.push_back('{cyc: cyc + LAT, last: (rem == 1)});
                rem--;
                last_issue = cyc;
                model_issues++;
            end else begin
                chk("opmode_stall", opmode, 0);
                chk("cea2_stall", cea2, 0);
                chk("ceb2_stall", ceb2, 0);
            end
            @(negedge clk);
            guard++;
        end
        if (rem > 0) chk("issue_timeout", rem, 0);
        opnd_gnt = 1'b0;
        guard = 0;
        #1;
        while (busy && guard < 40) begin
            @(negedge clk);
            #1;
            guard++;
        end
        chk("busy_fall_cycle", cyc, last_issue + LAT + 1);
        chk("sb_drained", sb.size(), 0);
        chk("ready_after", inst_ready, 1);
        chk("opcode_idle", opcode, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst         = 1'b0;
        inst_valid  = 1'b0;
        inst_opcode = '0;
        inst_count  = '0;
        opnd_gnt    = 1'b0;
        #1;
        chk("rst_res_valid", res_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_illegal", illegal, 0);
        chk("rst_opmode", opmode, 0);
        chk("rst_cea2", cea2, 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("ready_after_rst", inst_ready, 1);
        chk("rst_opnd_req", opnd_req, 0);

        // Directed cases
        gnt_pct = 100;
        run_inst(T_MULADD, 0);
        run_inst(T_CMULT, 3);
        gnt_q = '{1, 0, 0, 1, 1};
        run_inst(T_MULSUB, 2);
        run_inst(3'b011, 0);
        run_inst(T_NOP, 4);
        run_inst(3'b111, 2);

        // Reset during the second issue cycle of a count=5 instruction
        @(negedge clk);
        inst_valid = 1'b1; inst_opcode = T_CMULT; inst_count = 8'd5;
        @(negedge clk);
        inst_valid = 1'b0; opnd_gnt = 1'b1;
        #1;
        sb.push_back('{cyc: cyc + LAT, last: 1'b0});
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_res_valid", res_valid, 0);
        chk("arst_opnd_req", opnd_req, 0);
        chk("arst_opmode", opmode, 0);
        chk("arst_cea2", cea2, 0);
        chk("arst_usemult", usemult, 0);
        chk("arst_busy", busy, 0);
        chk("arst_opcode", opcode, 0);
        sb.delete();
        model_issues = 0;
        opnd_gnt = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (8) @(negedge clk);
        run_inst(T_MULADD, 0);

        // Full-range repeat count with random stalls
        gnt_pct = 70;
        run_inst(T_MULSUB, 255);

        // Randomized mix, including illegal opcodes
        for (int i = 0; i < 25; i++) begin
            gnt_pct = $urandom_range(30, 100);
            run_inst(3'($urandom_range(0, 7)), $urandom_range(0, 6));
        end

`ifdef ALU_ISSUE_CNT_EN
        gnt_q = '{1, 0, 1, 1, 0, 1, 1, 1, 1, 1};
        run_inst(T_CMULT, 7);
        chk("issue_cnt", issue_cnt, model_issues);
`endif

        repeat (10) @(negedge clk);
        chk("sb_final_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
